alu_result_stage: RTL and testbench

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage_pkg.sv | 31 +++
 rtl/alu_result_stage_skid_buf32.sv | 59 +++++
 rtl/alu_result_stage.sv | 98 +++++++++
 tb/tb_alu_result_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared ALU definitions: function-select codes, result-source encodings
// and the payload layout carried through the result stage.
package alu_result_stage_pkg;

  localparam int DATA_W  = 32;
  localparam int FLAGS_W = 4;
  localparam int ENTRY_W = DATA_W + FLAGS_W;

  // ALU function-select codes
  localparam logic [4:0] FS_PASS_S = 5'h00;
  localparam logic [4:0] FS_ADD    = 5'h02;
  localparam logic [4:0] FS_SUB    = 5'h04;
  localparam logic [4:0] FS_AND    = 5'h08;
  localparam logic [4:0] FS_OR     = 5'h09;
  localparam logic [4:0] FS_XOR    = 5'h0A;
  localparam logic [4:0] FS_MPY    = 5'h1E;
  localparam logic [4:0] FS_DIV    = 5'h1F;

  // Result source select; the reserved code behaves like Y_lo
  localparam logic [1:0] HILO_Y_LO = 2'b00;
  localparam logic [1:0] HILO_HI   = 2'b01;
  localparam logic [1:0] HILO_LO   = 2'b10;
  localparam logic [1:0] HILO_RSVD = 2'b11;

  // Pack flags above the data word so the skid buffer sees one vector
  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [DATA_W-1:0] data,
                                                    input logic [FLAGS_W-1:0] flags);
    return {flags, data};
  endfunction

endpackage

// File: rtl/alu_result_stage_skid_buf32.sv
// Two-entry valid/ready skid buffer. The main register drives the outputs,
// the skid register absorbs the one extra entry accepted while stalled.
// in_ready is a flop and only reflects skid occupancy.
module skid_buf32
  #(parameter int WIDTH = 36)
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
  );

  logic             main_valid;
  logic [WIDTH-1:0] main_data;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             in_ready_q;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer   = in_valid && in_ready_q;
  assign out_xfer  = main_valid && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  // Main/skid occupancy and data movement; main frees up when empty or draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready_q <= 1'b1;
    end else if (!main_valid || out_xfer) begin
      if (skid_valid) begin
        // in_ready was low, so nothing new can arrive this cycle
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (in_xfer) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
      in_ready_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: selects the result word (Y_lo / HI / LO), maintains the
// architectural HI/LO registers and sticky C/V for multiply/divide, and
// buffers {flags, data} through a two-entry skid buffer.
module alu_result_stage
  import alu_result_stage_pkg::*;
  #(
    parameter logic [4:0] FS_MPY = alu_result_stage_pkg::FS_MPY,
    parameter logic [4:0] FS_DIV = alu_result_stage_pkg::FS_DIV
  )
  (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  FS,
    input  logic [1:0]  hilo_sel,
    input  logic [31:0] Y_hi,
    input  logic [31:0] Y_lo,
    input  logic        C,
    input  logic        V,
    input  logic        N,
    input  logic        Z,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] D_out,
    output logic [3:0]  flags_out,
    output logic [31:0] HI,
    output logic [31:0] LO
  );

  logic [31:0]        hi_q;
  logic [31:0]        lo_q;
  logic               c_sticky;
  logic               v_sticky;
  logic               accept;
  logic               is_mul_div;
  logic [31:0]        sel_data;
  logic [3:0]         sel_flags;
  logic [ENTRY_W-1:0] buf_in;
  logic [ENTRY_W-1:0] buf_out;

  assign accept     = in_valid && in_ready;
  assign is_mul_div = (FS == FS_MPY) || (FS == FS_DIV);

  // Result word uses HI/LO as they stand before this transfer updates them
  always_comb begin
    sel_data = Y_lo;
    case (hilo_sel)
      HILO_HI: sel_data = hi_q;
      HILO_LO: sel_data = lo_q;
      default: sel_data = Y_lo;
    endcase
  end

  // Multiply/divide leave C and V undefined at the ALU, so reuse the last ones
  always_comb begin
    sel_flags = {C, V, N, Z};
    if (is_mul_div)
      sel_flags = {c_sticky, v_sticky, N, Z};
  end

  assign buf_in = pack_entry(sel_data, sel_flags);

  // HI/LO and sticky C/V update at acceptance, regardless of downstream stall
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      c_sticky <= 1'b0;
      v_sticky <= 1'b0;
    end else if (accept) begin
      if (is_mul_div) begin
        hi_q <= Y_hi;
        lo_q <= Y_lo;
      end else begin
        c_sticky <= C;
        v_sticky <= V;
      end
    end
  end

  skid_buf32 #(.WIDTH(ENTRY_W)) u_skid (
    .clk       (clk),
    .rst_n     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (buf_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out)
  );

  assign D_out     = buf_out[DATA_W-1:0];
  assign flags_out = buf_out[ENTRY_W-1:DATA_W];
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed and randomized checks for the ALU result stage.
module tb_alu_result_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  FS;
  logic [1:0]  hilo_sel;
  logic [31:0] Y_hi;
  logic [31:0] Y_lo;
  logic        C, V, N, Z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] D_out;
  logic [3:0]  flags_out;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] F_ADD = 5'h02;
  localparam logic [4:0] F_MPY = 5'h1E;
  localparam logic [4:0] F_DIV = 5'h1F;

  alu_result_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .FS        (FS),
    .hilo_sel  (hilo_sel),
    .Y_hi      (Y_hi),
    .Y_lo      (Y_lo),
    .C         (C),
    .V         (V),
    .N         (N),
    .Z         (Z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D_out     (D_out),
    .flags_out (flags_out),
    .HI        (HI),
    .LO        (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] fs, input logic [1:0] hs,
                       input logic [31:0] yh, input logic [31:0] yl,
                       input logic [3:0] f);
    in_valid = v; FS = fs; hilo_sel = hs; Y_hi = yh; Y_lo = yl;
    {C, V, N, Z} = f;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, F_ADD, 2'b00, 32'h0, 32'h0, 4'h0);
    out_ready = 1'b1;
    #12;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (D_out !== 32'h0) begin bad++; $display("FAIL rst_dout got=%h exp=0", D_out); end
    total++; if (flags_out !== 4'h0) begin bad++; $display("FAIL rst_flags got=%h exp=0", flags_out); end
    total++; if (HI !== 32'h0 || LO !== 32'h0) begin bad++; $display("FAIL rst_hilo got=%h/%h exp=0/0", HI, LO); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mpy_basic();
    drive(1'b1, F_MPY, 2'b00, 32'h1, 32'h2, 4'b0000);
    tick();
    total++; if (HI !== 32'h1) begin bad++; $display("FAIL mpy_hi got=%h exp=1", HI); end
    total++; if (LO !== 32'h2) begin bad++; $display("FAIL mpy_lo got=%h exp=2", LO); end
    total++; if (out_valid !== 1'b1 || D_out !== 32'h2) begin bad++; $display("FAIL mpy_dout got=%b/%h exp=1/2", out_valid, D_out); end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mpy_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    drive(1'b1, F_ADD, 2'b00, 32'h0, 32'd10, 4'b0000);
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_ready1 got=%b exp=1", in_ready); end
    Y_lo = 32'd11;
    tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready2 got=%b exp=0", in_ready); end
    Y_lo = 32'd12;
    tick();
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || D_out !== 32'd10) begin bad++; $display("FAIL stall_hold got=%b/%b/%0d exp=0/1/10", in_ready, out_valid, D_out); end
    out_ready = 1'b1;
    tick();
    total++; if (D_out !== 32'd11 || in_ready !== 1'b1) begin bad++; $display("FAIL stall_rel1 got=%0d/%b exp=11/1", D_out, in_ready); end
    tick();
    total++; if (D_out !== 32'd12 || out_valid !== 1'b1) begin bad++; $display("FAIL stall_rel2 got=%0d/%b exp=12/1", D_out, out_valid); end
    in_valid = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_hilo_fwd();
    drive(1'b1, F_MPY, 2'b00, 32'd9, 32'd0, 4'b0000);
    tick();
    drive(1'b1, F_MPY, 2'b01, 32'd5, 32'd7, 4'b0000);
    tick();
    total++; if (D_out !== 32'd9) begin bad++; $display("FAIL fwd_old_hi got=%0d exp=9", D_out); end
    total++; if (HI !== 32'd5 || LO !== 32'd7) begin bad++; $display("FAIL fwd_hilo got=%0d/%0d exp=5/7", HI, LO); end
    drive(1'b1, F_ADD, 2'b01, 32'd0, 32'd3, 4'b0000);
    tick();
    total++; if (D_out !== 32'd5) begin bad++; $display("FAIL fwd_new_hi got=%0d exp=5", D_out); end
    drive(1'b1, F_ADD, 2'b10, 32'd0, 32'd3, 4'b0000);
    tick();
    total++; if (D_out !== 32'd7) begin bad++; $display("FAIL fwd_lo got=%0d exp=7", D_out); end
    drive(1'b1, F_ADD, 2'b11, 32'd0, 32'd33, 4'b0000);
    tick();
    total++; if (D_out !== 32'd33) begin bad++; $display("FAIL fwd_rsvd got=%0d exp=33", D_out); end
    total++; if (HI !== 32'd5 || LO !== 32'd7) begin bad++; $display("FAIL add_keeps_hilo got=%0d/%0d exp=5/7", HI, LO); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_sticky();
    drive(1'b1, F_ADD, 2'b00, 32'd0, 32'd1, 4'b1100);
    tick();
    total++; if (flags_out !== 4'b1100) begin bad++; $display("FAIL sticky_add got=%b exp=1100", flags_out); end
    drive(1'b1, F_DIV, 2'b00, 32'd0, 32'd2, 4'bxx01);
    tick();
    total++; if (flags_out !== 4'b1101) begin bad++; $display("FAIL sticky_div got=%b exp=1101", flags_out); end
    drive(1'b1, F_ADD, 2'b00, 32'd0, 32'd3, 4'b0010);
    tick();
    total++; if (flags_out !== 4'b0010) begin bad++; $display("FAIL sticky_add2 got=%b exp=0010", flags_out); end
    drive(1'b1, F_MPY, 2'b00, 32'd0, 32'd4, 4'b1111);
    tick();
    total++; if (flags_out !== 4'b0011) begin bad++; $display("FAIL sticky_mpy got=%b exp=0011", flags_out); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midstall();
    out_ready = 1'b0;
    drive(1'b1, F_MPY, 2'b00, 32'hA, 32'hB, 4'b0000);
    tick();
    Y_hi = 32'hC; Y_lo = 32'hD;
    tick();
    total++; if (in_ready !== 1'b0 || HI !== 32'hC) begin bad++; $display("FAIL full_before_rst got=%b/%h exp=0/c", in_ready, HI); end
    in_valid = 1'b0;
    reset = 1'b0;
    #2;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL async_rst_hs got=%b/%b exp=0/1", out_valid, in_ready); end
    total++; if (HI !== 32'h0 || LO !== 32'h0) begin bad++; $display("FAIL async_rst_hilo got=%h/%h exp=0/0", HI, LO); end
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, F_ADD, 2'b00, 32'h0, 32'h55, 4'b0001);
    tick();
    total++; if (out_valid !== 1'b1 || D_out !== 32'h55) begin bad++; $display("FAIL first_edge got=%b/%h exp=1/55", out_valid, D_out); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [35:0] q[$];
    logic [35:0] exp_e;
    logic [31:0] seq;
    logic        ir;
    logic        in_x, out_x;
    int          outs;
    int          cyc;
    seq  = 32'h1000;
    outs = 0;
    cyc  = 0;
    while (outs < 10000 && cyc < 60000) begin
      drive(1'($urandom_range(0, 1)), F_ADD, 2'b00, 32'h0, seq, 4'($urandom_range(0, 15)));
      ir = in_ready;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      total++; if (in_ready !== ir) begin bad++; $display("FAIL ready_comb got=%b exp=%b", in_ready, ir); end
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      if (out_x) begin
        if (q.size() == 0) begin
          total++; bad++; $display("FAIL rand_extra got=%h exp=none", D_out);
        end else begin
          exp_e = q.pop_front();
          total++; if ({flags_out, D_out} !== exp_e) begin bad++; $display("FAIL rand_data got=%h exp=%h", {flags_out, D_out}, exp_e); end
        end
        outs++;
      end
      if (in_x) begin
        q.push_back({C, V, N, Z, seq});
        seq++;
      end
      tick();
      cyc++;
    end
    total++; if (outs < 10000) begin bad++; $display("FAIL rand_budget got=%0d exp=10000", outs); end
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mpy_basic();
    test_stall();
    test_hilo_fwd();
    test_sticky();
    test_reset_midstall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
